// File: rtl/heading_pkg.sv
`default_nettype none
// ============================================================================
// Module      : heading_pkg
// Description : Shared types, constants and frame-byte helper for heading_tx.
// Revision    : 1.0 - initial release
// ============================================================================
package heading_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam int         FRAME_BYTES = 4;

    typedef logic [2:0] heading_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Frame layout: SYNC, packed heading[1:0], heading[2], XOR checksum.
    function automatic logic [7:0] frame_byte(
        input logic [1:0] idx,
        input heading_t   h0,
        input heading_t   h1,
        input heading_t   h2
    );
        logic [7:0] w_b1;
        logic [7:0] w_b2;
        logic [7:0] w_byte;
        w_b1 = {2'b00, h1, h0};
        w_b2 = {5'b00000, h2};
        case (idx)
            2'd0:    w_byte = SYNC_BYTE;
            2'd1:    w_byte = w_b1;
            2'd2:    w_byte = w_b2;
            default: w_byte = SYNC_BYTE ^ w_b1 ^ w_b2;
        endcase
        return w_byte;
    endfunction

endpackage
`default_nettype wire

// File: rtl/heading_tx_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Start/data/stop bit shifter with a byte-done strobe that
//               marks the final cycle of each stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer
    import heading_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       byte_done,
    output tx_state_t  state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_stop_pre = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_byte_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (load) begin
                        r_state   <= START;
                        r_bit_cnt <= '0;
                        r_shift   <= data;
                        r_tx      <= 1'b0;
                    end
                end

                START: begin
                    if (r_bit_cnt == c_bit_last) begin
                        r_bit_cnt <= '0;
                        r_state   <= DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (r_bit_cnt == c_bit_last) begin
                        r_bit_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_state   <= STOP;
                            r_tx      <= 1'b1;
                        end else begin
                            // LSB goes first, so the next bit sits at [1].
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (r_bit_cnt == c_bit_last) begin
                        r_bit_cnt <= '0;
                        // A load here chains the next byte with no idle gap.
                        if (load) begin
                            r_state <= START;
                            r_shift <= data;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == c_stop_pre) begin
                            r_byte_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx        = r_tx;
    assign byte_done = r_byte_done;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: rtl/heading_tx.sv
`default_nettype none
// ============================================================================
// Module      : heading_tx
// Description : Frame sequencer that latches a heading vector and sends it
//               as a 4-byte serial telemetry frame (SYNC, B1, B2, CHK).
// Revision    : 1.0 - initial release
// ============================================================================
module heading_tx
    import heading_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    input  heading_t heading [3],
    input  logic     heading_valid,
    output logic     heading_ready,
    output logic     tx_serial,
    output logic     tx_busy,
    output logic     frame_done
);

    tx_state_t  w_ser_state;
    logic       w_byte_done;
    logic       w_accept;
    logic       w_last_byte;
    logic       w_load;
    logic [1:0] w_next_idx;
    logic [7:0] w_load_byte;
    logic [1:0] r_byte_idx;
    heading_t   r_heading [3];

    assign heading_ready = rst_n && (w_ser_state == IDLE);
    assign w_accept      = heading_valid && heading_ready;
    assign w_last_byte   = (r_byte_idx == 2'(FRAME_BYTES - 1));

    // Byte 0 is the constant SYNC, so the same-edge latch is never needed.
    assign w_next_idx  = w_accept ? 2'd0 : (r_byte_idx + 2'd1);
    assign w_load      = w_accept || (w_byte_done && !w_last_byte);
    assign w_load_byte = frame_byte(w_next_idx, r_heading[0], r_heading[1], r_heading[2]);

    assign tx_busy    = (w_ser_state != IDLE);
    assign frame_done = w_byte_done && w_last_byte;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byte_idx <= '0;
            r_heading  <= '{default: '0};
        end else begin
            if (w_accept) begin
                r_heading  <= heading;
                r_byte_idx <= '0;
            end else if (w_byte_done) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end
        end
    end

    byte_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .data      (w_load_byte),
        .tx        (tx_serial),
        .byte_done (w_byte_done),
        .state     (w_ser_state)
    );

endmodule
`default_nettype wire

// File: tb/tb_heading_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_heading_tx
// Description : Self-checking bench for heading_tx at CLKS_PER_BIT 8 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_heading_tx;

    typedef logic [2:0] hvec_t [3];

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst_n_v [2];
    logic  hv      [2];
    logic  rdy_v   [2];
    logic  tx_v    [2];
    logic  busy_v  [2];
    logic  done_v  [2];
    hvec_t hd      [2];

    int n_vec = 0;
    int n_bad = 0;

    bit rec_on  = 1'b0;
    int rec_sel = 0;
    bit trace[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame bytes straight from the telemetry format rules.
    function automatic void model_bytes(input hvec_t h, output logic [7:0] b [4]);
        b[0] = 8'hA5;
        b[1] = 8'(h[1]) * 8'd8 + 8'(h[0]);
        b[2] = 8'(h[2]);
        b[3] = b[0] ^ b[1] ^ b[2];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int N = (g == 0) ? 8 : 2;

        heading_tx #(
            .CLKS_PER_BIT (N)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n_v[g]),
            .heading       (hd[g]),
            .heading_valid (hv[g]),
            .heading_ready (rdy_v[g]),
            .tx_serial     (tx_v[g]),
            .tx_busy       (busy_v[g]),
            .frame_done    (done_v[g])
        );

        // Expected {tx, busy, done} per cycle, queued for a whole frame.
        logic [2:0] q[$];
        logic [2:0] cur  = 3'b100;
        bit         idle = 1'b1;
        logic [7:0] mb [4];
        logic       bv;

        always @(posedge clk) begin
            if (!rst_n_v[g]) begin
                q.delete();
                cur  = 3'b100;
                idle = 1'b1;
            end else if (q.size() > 0) begin
                cur  = q.pop_front();
                idle = 1'b0;
            end else if (idle && hv[g]) begin
                model_bytes(hd[g], mb);
                for (int bi = 0; bi < 4; bi++) begin
                    for (int k = 0; k < 10; k++) begin
                        bv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : mb[bi][k-1];
                        for (int r = 0; r < N; r++) begin
                            q.push_back({bv, 1'b1, (bi == 3 && k == 9 && r == N - 1)});
                        end
                    end
                end
                cur  = q.pop_front();
                idle = 1'b0;
            end else begin
                cur  = 3'b100;
                idle = 1'b1;
            end
        end

        always @(negedge clk) begin
            check($sformatf("dut%0d cycle {tx,busy,done,ready}", g),
                  {tx_v[g], busy_v[g], done_v[g], rdy_v[g]},
                  {cur, idle && rst_n_v[g]});
        end
    end

    always @(negedge clk) begin
        if (rec_on) trace.push_back(tx_v[rec_sel]);
    end

    task automatic decode(input int n, output int nb, output logic [7:0] o [8], output int stop_err);
        int p;
        p        = 0;
        nb       = 0;
        stop_err = 0;
        o        = '{default: 8'h00};
        while (nb < 8 && p + 10 * n <= trace.size()) begin
            if (trace[p] == 1'b0) begin
                for (int j = 0; j < 8; j++) o[nb][j] = trace[p + (1 + j) * n + n / 2];
                if (trace[p + 9 * n + n / 2] != 1'b1) stop_err++;
                nb++;
                p = p + 9 * n + n / 2 + 1;
            end else begin
                p++;
            end
        end
    endtask

    task automatic check_frame(input string nm, input int n, input int exp_nb, input logic [7:0] e [8]);
        int         nb;
        int         se;
        logic [7:0] o [8];
        decode(n, nb, o, se);
        check({nm, " byte count"}, nb, exp_nb);
        check({nm, " stop bits"}, se, 0);
        for (int i = 0; i < exp_nb; i++) check($sformatf("%s byte %0d", nm, i), o[i], e[i]);
    endtask

    task automatic send(input int g, input hvec_t h, input bit hold);
        @(posedge clk);
        #1;
        hd[g] = h;
        hv[g] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) hv[g] = 1'b0;
        check($sformatf("dut%0d busy after accept", g), busy_v[g], 1);
    endtask

    task automatic wait_done(input int g, input int bound, output int k);
        k = 0;
        while (k < bound) begin
            @(negedge clk);
            k++;
            if (done_v[g]) break;
        end
        check($sformatf("dut%0d frame_done seen", g), done_v[g], 1);
    endtask

    initial begin
        hvec_t      h;
        logic [7:0] mb [4];
        int         k;
        int         pulses;

        rst_n_v = '{1'b0, 1'b0};
        hv      = '{1'b0, 1'b0};
        hd[0]   = '{3'd0, 3'd0, 3'd0};
        hd[1]   = '{3'd0, 3'd0, 3'd0};

        // Model pinned to hand-computed frames.
        h = '{3'd7, 3'd2, 3'd5};
        model_bytes(h, mb);
        check("model {7,2,5} B0", mb[0], 8'hA5);
        check("model {7,2,5} B1", mb[1], 8'h17);
        check("model {7,2,5} B2", mb[2], 8'h05);
        check("model {7,2,5} CHK", mb[3], 8'hB7);
        h = '{3'd7, 3'd7, 3'd7};
        model_bytes(h, mb);
        check("model {7,7,7} B1", mb[1], 8'h3F);
        check("model {7,7,7} CHK", mb[3], 8'h9D);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("dut%0d reset tx", g), tx_v[g], 1);
            check($sformatf("dut%0d reset busy", g), busy_v[g], 0);
            check($sformatf("dut%0d reset done", g), done_v[g], 0);
            check($sformatf("dut%0d reset ready", g), rdy_v[g], 0);
        end
        @(posedge clk);
        #1;
        rst_n_v = '{1'b1, 1'b1};
        @(negedge clk);
        check("dut0 ready after release", rdy_v[0], 1);
        check("dut1 ready after release", rdy_v[1], 1);

        // Basic frame, N=8.
        trace.delete();
        rec_sel = 0;
        rec_on  = 1'b1;
        send(0, '{3'd7, 3'd2, 3'd5}, 1'b0);
        wait_done(0, 400, k);
        check("basic frame_done cycle", k, 320);
        @(negedge clk);
        check("basic ready after frame", rdy_v[0], 1);
        rec_on = 1'b0;
        check_frame("basic", 8, 4, '{8'hA5, 8'h17, 8'h05, 8'hB7, 8'h00, 8'h00, 8'h00, 8'h00});

        // Heading altered one cycle after acceptance.
        trace.delete();
        rec_on = 1'b1;
        send(0, '{3'd1, 3'd3, 3'd6}, 1'b0);
        hd[0] = '{3'd4, 3'd4, 3'd4};
        wait_done(0, 400, k);
        @(negedge clk);
        rec_on = 1'b0;
        check_frame("stable", 8, 4, '{8'hA5, 8'h19, 8'h06, 8'hBA, 8'h00, 8'h00, 8'h00, 8'h00});

        // Back-to-back frames with valid held high.
        trace.delete();
        rec_on = 1'b1;
        send(0, '{3'd0, 3'd0, 3'd0}, 1'b1);
        hd[0] = '{3'd7, 3'd7, 3'd7};
        wait_done(0, 400, k);
        check("b2b first frame_done cycle", k, 320);
        @(negedge clk);
        check("b2b idle gap ready", rdy_v[0], 1);
        check("b2b idle gap tx", tx_v[0], 1);
        @(posedge clk);
        #1;
        hv[0] = 1'b0;
        check("b2b second accept busy", busy_v[0], 1);
        wait_done(0, 400, k);
        check("b2b second frame_done cycle", k, 320);
        @(negedge clk);
        rec_on = 1'b0;
        check_frame("b2b", 8, 8, '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'h3F, 8'h07, 8'h9D});

        // Reset during byte 2, data bit 4.
        send(0, '{3'd5, 3'd5, 3'd5}, 1'b0);
        repeat (203) @(posedge clk);
        #1;
        check("midframe busy before reset", busy_v[0], 1);
        rst_n_v[0] = 1'b0;
        @(posedge clk);
        #1;
        check("abort tx", tx_v[0], 1);
        check("abort busy", busy_v[0], 0);
        check("abort done", done_v[0], 0);
        check("abort ready in reset", rdy_v[0], 0);
        rst_n_v[0] = 1'b1;
        @(negedge clk);
        check("abort ready after release", rdy_v[0], 1);
        pulses = 0;
        repeat (400) begin
            @(negedge clk);
            if (done_v[0]) pulses++;
        end
        check("abort no frame_done", pulses, 0);

        // Minimum bit time, N=2.
        trace.delete();
        rec_sel = 1;
        rec_on  = 1'b1;
        send(1, '{3'd3, 3'd6, 3'd1}, 1'b0);
        wait_done(1, 100, k);
        check("N=2 frame_done cycle", k, 80);
        @(negedge clk);
        rec_on = 1'b0;
        check_frame("N=2", 2, 4, '{8'hA5, 8'h33, 8'h01, 8'h97, 8'h00, 8'h00, 8'h00, 8'h00});

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/heading_tx.md
HEADING_TX -- requirements
Module: heading_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: clock cycles per serial bit, legal range 2..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port heading, input, 3x3 bits (unpacked [3] of [2:0]): heading vector from AUV control.
REQ-005 SHALL have port heading_valid, input, 1 bit: heading is presented for transmission.
REQ-006 SHALL have port heading_ready, output, 1 bit: block can accept a heading.
REQ-007 SHALL have port tx_serial, output, 1 bit: serial telemetry line, idle high.
REQ-008 SHALL have port tx_busy, output, 1 bit: a frame is in progress.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-010 SHALL accept a heading on a rising edge where heading_valid=1 and heading_ready=1, and latch all three heading elements on that edge.
REQ-011 SHALL drive heading_ready=1 only in IDLE, combinationally from state.
REQ-012 SHALL ignore heading changes after acceptance; the latched copy is sent.
REQ-013 SHALL send a frame of 4 bytes in order: SYNC=0xA5, B1={2'b00, heading[1], heading[0]}, B2={5'b0, heading[2]}, CHK=SYNC^B1^B2.
REQ-014 SHALL encode each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit is held for exactly CLKS_PER_BIT cycles.
REQ-015 SHALL use states IDLE -> START -> DATA -> STOP, with STOP -> START when byte index < 3 and STOP -> IDLE after byte index 3.
REQ-016 SHALL drive the first start bit on tx_serial in the cycle after acceptance; the frame lasts exactly 40*CLKS_PER_BIT cycles.
REQ-017 SHALL hold tx_serial=1 in IDLE and during stop bits, with no inter-byte gap.
REQ-018 SHALL keep tx_busy=1 from the cycle after acceptance through the last cycle of the final stop bit.
REQ-019 SHALL assert frame_done for exactly the last cycle of the final stop bit of byte 3.
REQ-020 SHALL return to IDLE with heading_ready=1 the cycle after frame_done.
REQ-021 SHALL, when heading_valid is held high, accept the next heading on that IDLE cycle, so frames are separated by exactly one idle-high cycle.
REQ-022 SHALL use a bit-time counter sized $clog2(CLKS_PER_BIT), a 3-bit bit index and a 2-bit byte index, all wrapping to 0 at their terminal counts.

Reset
REQ-023 SHALL, while rst_n=0 at a clock edge, force state=IDLE, all counters=0, tx_serial=1, tx_busy=0, frame_done=0 and the heading latch=0.
REQ-024 SHALL, on reset mid-frame, abort the frame immediately; tx_serial is high from the next cycle and no frame_done pulse is produced.
REQ-025 SHALL drive heading_ready=0 while rst_n=0, and 1 from the first cycle after rst_n deasserts.

Structure
REQ-026 SHALL place the state enum, SYNC_BYTE=8'hA5, FRAME_BYTES=4 and the heading element type (logic [2:0]) in shared package heading_pkg.
REQ-027 SHALL be implemented as one sub-module, byte_serializer (start/data/stop shifter, byte-done strobe), instantiated by a heading_tx frame sequencer.

Verification
REQ-028 SHALL cover a basic frame: CLKS_PER_BIT=8, heading={7,2,5} (index 0,1,2) -> bytes A5,17,05,B7 on tx_serial, frame_done exactly 320 cycles after acceptance.
REQ-029 SHALL cover back-to-back frames: heading_valid held high with headings {0,0,0} then {7,7,7} -> bytes A5,00,00,A5, one idle cycle, then A5,3F,07,9D.
REQ-030 SHALL cover input stability after acceptance: heading changed 1 cycle after acceptance -> transmitted bytes reflect the originally latched value only.
REQ-031 SHALL cover reset mid-frame: rst_n low during byte 2 bit 4 -> tx_serial=1, tx_busy=0 next cycle, no frame_done, heading_ready=1 after release.
REQ-032 SHALL cover the minimum bit time: CLKS_PER_BIT=2 -> every bit 2 cycles wide, frame 80 cycles, checksum correct.
